// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM encodings and register index constants.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  localparam logic [4:0] X0_IDX = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; value is registered, clear wins over increment.
// Holds at all-ones instead of wrapping; no backpressure.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, redirect, memory wait with watchdog, ebreak halt.
// Enables/clears are combinational (zero latency); a memory wait freezes every stage until the acknowledge.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rfwe,
  input  logic             ex_memrd,
  input  logic             ex_redirect,
  input  logic             ebreak_ex,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             pc_wen,
  output logic             if_id_wen,
  output logic             id_ex_wen,
  output logic             ex_mem_wen,
  output logic             mem_wb_wen,
  output logic             if_id_clear,
  output logic             id_ex_clear,
  output logic             ex_mem_clear,
  output logic             mem_wb_clear,
  output logic             halted,
  output logic             mem_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int                WAIT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_mem_timeout;
  logic              w_timeout_set;
  logic              w_load_use;
  logic              w_mstall;
  logic              w_flush_act;
  logic              w_wait_inc;
  logic              w_wait_clr;
  logic [WAIT_W-1:0] w_wait_cnt;

  assign w_load_use = ex_memrd && ex_rfwe && (ex_rd != X0_IDX) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));
  assign w_mstall   = mem_req && !mem_ready;

  always_comb begin
    pc_wen       = 1'b1;
    if_id_wen    = 1'b1;
    id_ex_wen    = 1'b1;
    ex_mem_wen   = 1'b1;
    mem_wb_wen   = 1'b1;
    if_id_clear  = 1'b0;
    id_ex_clear  = 1'b0;
    ex_mem_clear = 1'b0;
    mem_wb_clear = 1'b0;
    w_flush_act  = 1'b0;
    if (!rstn) begin
      pc_wen       = 1'b0;
      if_id_wen    = 1'b0;
      id_ex_wen    = 1'b0;
      ex_mem_wen   = 1'b0;
      mem_wb_wen   = 1'b0;
      if_id_clear  = 1'b1;
      id_ex_clear  = 1'b1;
      ex_mem_clear = 1'b1;
      mem_wb_clear = 1'b1;
    end else if (w_mstall && (r_state != ST_HALT)) begin
      pc_wen     = 1'b0;
      if_id_wen  = 1'b0;
      id_ex_wen  = 1'b0;
      ex_mem_wen = 1'b0;
      mem_wb_wen = 1'b0;
    end else if (r_state == ST_HALT) begin
      // Bubbles drain the back end; after a watchdog halt the hung access is frozen too.
      pc_wen      = 1'b0;
      if_id_wen   = 1'b0;
      id_ex_clear = 1'b1;
      if (r_mem_timeout) begin
        ex_mem_wen = 1'b0;
        mem_wb_wen = 1'b0;
      end
    end else if (ebreak_ex) begin
      pc_wen      = 1'b0;
      if_id_wen   = 1'b0;
      id_ex_clear = 1'b1;
    end else if (ex_redirect) begin
      if_id_clear = 1'b1;
      id_ex_clear = 1'b1;
      w_flush_act = 1'b1;
    end else if (w_load_use) begin
      pc_wen      = 1'b0;
      if_id_wen   = 1'b0;
      id_ex_clear = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mstall) begin
          w_state_nxt = ST_MEM_WAIT;
        end else if (ebreak_ex) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_MEM_WAIT: begin
        // The release cycle behaves like RUN, so an ebreak there still halts.
        if (!w_mstall) begin
          w_state_nxt = ebreak_ex ? ST_HALT : ST_RUN;
        end else if (w_wait_cnt == WAIT_LAST) begin
          w_state_nxt   = ST_HALT;
          w_timeout_set = 1'b1;
        end
      end
      ST_HALT: begin
        if (resume && !r_mem_timeout) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_RUN;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_timeout_set) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  assign w_wait_inc = (r_state == ST_MEM_WAIT) && (w_state_nxt == ST_MEM_WAIT);
  assign w_wait_clr = !w_wait_inc;

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_wait_inc),
    .i_clr (w_wait_clr),
    .o_cnt (w_wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (!pc_wen),
    .i_clr (1'b0),
    .o_cnt (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_flush_act),
    .i_clr (1'b0),
    .o_cnt (flush_count)
  );

  assign state       = r_state;
  assign halted      = (r_state == ST_HALT);
  assign mem_timeout = r_mem_timeout;

endmodule
